// File: rtl/fir2d_mac5x5.sv
// fir2d_mac5x5: pipelined 5x5 multiply-accumulate core of the 2D FIR filter.
// Takes one 5-pixel column per valid clock and keeps a 5x5 window.
// Produces one rounded, saturated pixel per column, 5 clocks later.
// Sidebands {dv, hs, vs} are delayed to match the data.
// Optional feature macro: FIR_BYPASS_EN adds bypass_i.
//   With bypass_i=1, the output is the window centre pixel at the same latency.
module fir2d_mac5x5 #(
  parameter int PIX_W      = 8,
  parameter int COEFF_W    = 16,
  parameter int COEFF_FRAC = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dv_i,
  input  logic                      hs_i,
  input  logic                      vs_i,
  input  logic [PIX_W-1:0]          px0_i,
  input  logic [PIX_W-1:0]          px1_i,
  input  logic [PIX_W-1:0]          px2_i,
  input  logic [PIX_W-1:0]          px3_i,
  input  logic [PIX_W-1:0]          px4_i,
  input  logic signed [COEFF_W-1:0] coeff00, coeff01, coeff02, coeff03, coeff04,
  input  logic signed [COEFF_W-1:0] coeff10, coeff11, coeff12, coeff13, coeff14,
  input  logic signed [COEFF_W-1:0] coeff20, coeff21, coeff22, coeff23, coeff24,
  input  logic signed [COEFF_W-1:0] coeff30, coeff31, coeff32, coeff33, coeff34,
  input  logic signed [COEFF_W-1:0] coeff40, coeff41, coeff42, coeff43, coeff44,
`ifdef FIR_BYPASS_EN
  input  logic                      bypass_i,
`endif
  output logic                      dv_o,
  output logic                      hs_o,
  output logic                      vs_o,
  output logic [PIX_W-1:0]          pix_o
);

  localparam int PROD_W = PIX_W + 1 + COEFF_W;   // unsigned pixel made signed, times coefficient
  localparam int ROW_W  = PROD_W + 3;            // five products need three guard bits
  localparam int TOT_W  = PIX_W + COEFF_W + 6;   // five row sums
  localparam logic signed [TOT_W-1:0] RND     = TOT_W'((1 << COEFF_FRAC) >> 1);
  localparam logic signed [TOT_W-1:0] MAX_PIX = TOT_W'((1 << PIX_W) - 1);

  logic signed [COEFF_W-1:0] coeff [5][5];
  logic [PIX_W-1:0]          win   [5][5];
  logic signed [PROD_W-1:0]  prod  [5][5];
  logic signed [ROW_W-1:0]   row_acc [5];
  logic signed [ROW_W-1:0]   row_sum [5];
  logic signed [TOT_W-1:0]   tot_acc;
  logic signed [TOT_W-1:0]   total;
  logic signed [TOT_W-1:0]   rounded;
  logic [PIX_W-1:0]          sat_pix;
  logic [2:0]                sb [5];

  assign coeff[0] = '{coeff00, coeff01, coeff02, coeff03, coeff04};
  assign coeff[1] = '{coeff10, coeff11, coeff12, coeff13, coeff14};
  assign coeff[2] = '{coeff20, coeff21, coeff22, coeff23, coeff24};
  assign coeff[3] = '{coeff30, coeff31, coeff32, coeff33, coeff34};
  assign coeff[4] = '{coeff40, coeff41, coeff42, coeff43, coeff44};

  // Window: shift a new column in on every valid clock, hold otherwise.
  // NOTE: the window is a bank of flops, not a RAM, so it is cleared by reset like any register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          win[r][c] <= '0;
    end else if (dv_i) begin
      for (int r = 0; r < 5; r++)
        for (int c = 1; c < 5; c++)
          win[r][c] <= win[r][c-1];
      win[0][0] <= px0_i;
      win[1][0] <= px1_i;
      win[2][0] <= px2_i;
      win[3][0] <= px3_i;
      win[4][0] <= px4_i;
    end
  end

  // Stage 1: 25 signed products; coefficients are taken live every clock.
  // NOTE: sequential state uses non-blocking assignments so every stage sees last cycle's values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          prod[r][c] <= '0;
    end else begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          prod[r][c] <= PROD_W'($signed({1'b0, win[r][c]})) * PROD_W'(coeff[r][c]);
    end
  end

  // Row and grand-total adders, sign-extended to their guard widths.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    tot_acc = '0;
    for (int r = 0; r < 5; r++) begin
      row_acc[r] = '0;
      for (int c = 0; c < 5; c++)
        row_acc[r] = row_acc[r] + ROW_W'(prod[r][c]);
    end
    for (int r = 0; r < 5; r++)
      tot_acc = tot_acc + TOT_W'(row_sum[r]);
  end

  // Stages 2 and 3: register the row sums, then the total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 5; r++)
        row_sum[r] <= '0;
      total <= '0;
    end else begin
      for (int r = 0; r < 5; r++)
        row_sum[r] <= row_acc[r];
      total <= tot_acc;
    end
  end

  // Round to nearest, drop the fractional bits, clamp to the pixel range.
  always_comb begin
    rounded = (total + RND) >>> COEFF_FRAC;
    sat_pix = rounded[PIX_W-1:0];
    if (rounded < 0)
      sat_pix = '0;
    else if (rounded > MAX_PIX)
      sat_pix = '1;
  end

`ifdef FIR_BYPASS_EN
  logic             byp_w, byp1, byp2, byp3;
  logic [PIX_W-1:0] ctr1, ctr2, ctr3;

  // Bypass flag and centre pixel travel alongside the arithmetic stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_w <= 1'b0;
      byp1  <= 1'b0;
      byp2  <= 1'b0;
      byp3  <= 1'b0;
      ctr1  <= '0;
      ctr2  <= '0;
      ctr3  <= '0;
    end else begin
      byp_w <= bypass_i;
      byp1  <= byp_w;
      byp2  <= byp1;
      byp3  <= byp2;
      ctr1  <= win[2][2];
      ctr2  <= ctr1;
      ctr3  <= ctr2;
    end
  end

  // Stage 4: output register, filtered or bypassed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_o <= '0;
    else     pix_o <= byp3 ? ctr3 : sat_pix;
  end
`else
  // Stage 4: output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_o <= '0;
    else     pix_o <= sat_pix;
  end
`endif

  // Sideband delay line, five stages deep to match the data path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++)
        sb[i] <= '0;
    end else begin
      sb[0] <= {dv_i, hs_i, vs_i};
      for (int i = 1; i < 5; i++)
        sb[i] <= sb[i-1];
    end
  end

  assign dv_o = sb[4][2];
  assign hs_o = sb[4][1];
  assign vs_o = sb[4][0];

endmodule

// File: tb/tb_fir2d_mac5x5.sv
// Directed bench for fir2d_mac5x5.
// Covers identity, box, saturation, rounding, sidebands and mid-line reset.
// Adds a bypass check when FIR_BYPASS_EN is defined.
module tb_fir2d_mac5x5;

  logic              clk = 1'b0;
  logic              rst;
  logic              dv_i, hs_i, vs_i;
  logic [7:0]        px0_i, px1_i, px2_i, px3_i, px4_i;
  logic signed [15:0] cf [5][5];
`ifdef FIR_BYPASS_EN
  logic              bypass_i;
`endif
  logic              dv_o, hs_o, vs_o;
  logic [7:0]        pix_o;

  int total = 0;
  int bad   = 0;

  fir2d_mac5x5 dut (
    .clk(clk), .rst(rst), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .px0_i(px0_i), .px1_i(px1_i), .px2_i(px2_i), .px3_i(px3_i), .px4_i(px4_i),
    .coeff00(cf[0][0]), .coeff01(cf[0][1]), .coeff02(cf[0][2]), .coeff03(cf[0][3]), .coeff04(cf[0][4]),
    .coeff10(cf[1][0]), .coeff11(cf[1][1]), .coeff12(cf[1][2]), .coeff13(cf[1][3]), .coeff14(cf[1][4]),
    .coeff20(cf[2][0]), .coeff21(cf[2][1]), .coeff22(cf[2][2]), .coeff23(cf[2][3]), .coeff24(cf[2][4]),
    .coeff30(cf[3][0]), .coeff31(cf[3][1]), .coeff32(cf[3][2]), .coeff33(cf[3][3]), .coeff34(cf[3][4]),
    .coeff40(cf[4][0]), .coeff41(cf[4][1]), .coeff42(cf[4][2]), .coeff43(cf[4][3]), .coeff44(cf[4][4]),
`ifdef FIR_BYPASS_EN
    .bypass_i(bypass_i),
`endif
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .pix_o(pix_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 ns after the edge, away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one column (all five rows equal) and advance a clock.
  task automatic col(input logic dv, input logic hs, input logic vs, input logic [7:0] v);
    dv_i = dv; hs_i = hs; vs_i = vs;
    px0_i = v; px1_i = v; px2_i = v; px3_i = v; px4_i = v;
    step();
  endtask

  task automatic set_coeffs(input logic signed [15:0] all, input logic signed [15:0] ctr);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        cf[r][c] = all;
    cf[2][2] = ctr;
  endtask

  // Fill the window with v, then check the last column's result and the idle slot after it.
  task automatic flush_check(input string tag, input logic [7:0] v, input logic [7:0] exp);
    for (int i = 0; i < 6; i++) col(1'b1, 1'b0, 1'b0, v);
    dv_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check({tag, "_pix"}, 32'(pix_o), 32'(exp));
    check({tag, "_dv"},  32'(dv_o), 32'd1);
    step();
    check({tag, "_gap_dv"}, 32'(dv_o), 32'd0);
  endtask

  logic [8:0] dv_pat;
  logic [8:0] hs_pat;
  logic [8:0] vs_pat;
  int         found;
  logic [7:0] first_pix;

  initial begin
    rst = 1'b1;
    dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    px0_i = '0; px1_i = '0; px2_i = '0; px3_i = '0; px4_i = '0;
    set_coeffs(16'sd0, 16'sd0);
`ifdef FIR_BYPASS_EN
    bypass_i = 1'b0;
`endif
    #3;
    check("reset_pix", 32'(pix_o), 32'd0);
    check("reset_dv",  32'(dv_o),  32'd0);
    check("reset_hs",  32'(hs_o),  32'd0);
    check("reset_vs",  32'(vs_o),  32'd0);
    step();
    step();
    rst = 1'b0;

    // Identity: centre tap at gain 1.0, column m carries 10*(m+1); centre lags two columns.
    set_coeffs(16'sd0, 16'sd256);
    for (int i = 0; i < 25; i++) begin
      if (i >= 5) begin
        check("ident_dv", 32'(dv_o), 32'd1);
        check("ident_pix", 32'(pix_o), (i - 5 >= 2) ? 32'(10 * (i - 6)) : 32'd0);
      end
      if (i < 20) col(1'b1, 1'b0, 1'b0, 8'(10 * (i + 1)));
      else        col(1'b0, 1'b0, 1'b0, 8'd0);
    end

    // Box: 25 taps of 10 over 200 -> (50000+128)>>8 = 195.
    set_coeffs(16'sd10, 16'sd10);
    flush_check("box", 8'd200, 8'd195);

    // Saturation high and low.
    set_coeffs(16'sd0, 16'sd1024);
    flush_check("sat_hi", 8'd100, 8'd255);
    set_coeffs(16'sd0, -16'sd256);
    flush_check("sat_lo", 8'd100, 8'd0);

    // Rounding: 3*0.5 -> 2, 1*0.5 -> 1.
    set_coeffs(16'sd0, 16'sd128);
    flush_check("rnd_3", 8'd3, 8'd2);
    flush_check("rnd_1", 8'd1, 8'd1);

    // Sidebands: dv 1,0,1,1 with an hs pulse and a vs pulse; pattern bit i is cycle i.
    dv_pat = 9'b000001101;
    hs_pat = 9'b000000001;
    vs_pat = 9'b000000100;
    for (int i = 0; i < 9; i++) begin
      if (i >= 5) begin
        check("sb_dv", 32'(dv_o), 32'(dv_pat[i-5]));
        check("sb_hs", 32'(hs_o), 32'(hs_pat[i-5]));
        check("sb_vs", 32'(vs_o), 32'(vs_pat[i-5]));
      end
      col(dv_pat[i], hs_pat[i], vs_pat[i], 8'd50);
    end

    // Mid-line reset with valid data in flight.
    set_coeffs(16'sd10, 16'sd10);
    for (int i = 0; i < 6; i++) col(1'b1, 1'b1, 1'b1, 8'd200);
    check("pre_rst_dv", 32'(dv_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_pix", 32'(pix_o), 32'd0);
    check("rst_dv",  32'(dv_o),  32'd0);
    check("rst_hs",  32'(hs_o),  32'd0);
    check("rst_vs",  32'(vs_o),  32'd0);
    dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    // One column of 200 into a cleared window: 5*2000 -> (10000+128)>>8 = 39.
    col(1'b1, 1'b0, 1'b0, 8'd200);
    dv_i = 1'b0;
    found = 0;
    first_pix = '0;
    for (int n = 1; n <= 10; n++) begin
      if (dv_o && found == 0) begin
        found = n;
        first_pix = pix_o;
      end
      step();
    end
    check("post_rst_latency", 32'(found), 32'd5);
    check("post_rst_pix", 32'(first_pix), 32'd39);

`ifdef FIR_BYPASS_EN
    // Bypass: zero coefficients, output follows the centre pixel.
    bypass_i = 1'b1;
    set_coeffs(16'sd0, 16'sd0);
    flush_check("bypass", 8'd77, 8'd77);
    bypass_i = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir2d_mac5x5.md
# fir2d_mac5x5

- Pipelined 5x5 multiply-accumulate core of the 2D FIR filter.
- Consumes one 5-pixel column per valid clock from the line buffers and the 25 signed coefficients published by the coefficient loader.
- Keeps a 5x5 pixel window and produces one saturated, rounded output pixel per input column, with video sidebands delayed to match.
- Sits between the line-buffer stage and the video output.

## Interface
- PIX_W, 8, pixel width (unsigned)
- COEFF_W, 16, coefficient width (signed two's complement)
- COEFF_FRAC, 8, fractional bits of coefficients; a coefficient of 2^COEFF_FRAC is gain 1.0
- clk  input  1  pixel clock; single clock domain
- rst  input  1  reset; asynchronous and active-high
- dv_i  input  1  input column valid
- hs_i  input  1  horizontal sync, delay-matched only
- vs_i  input  1  vertical sync, delay-matched only
- px0_i..px4_i  input  PIX_W each  current column, row 0 (oldest line) to row 4 (newest line)
- coeff00..coeff44  input  COEFF_W each, signed  coeffRC multiplies window row R, column C
- bypass_i  input  1  present only with FIR_BYPASS_EN
- dv_o  output  1  output pixel valid
- hs_o  output  1  delayed hs_i
- vs_o  output  1  delayed vs_i
- pix_o  output  PIX_W  filtered pixel

## Operation
- Window w[r][c], r,c = 0..4; column 0 holds the newest sample.
- On a clock with dv_i=1: every row shifts, w[r][c] <= w[r][c-1] for c = 1..4, and w[r][0] <= px{r}_i.
- With dv_i=0 the window holds.
- Stage 1 (products): p[r][c] = {1'b0, w[r][c]} × coeffRC.
  - Signed, PIX_W+1+COEFF_W = 25 bits.
  - Coefficients are sampled here every clock, with no internal shadowing. A coefficient change takes effect on the next product-stage clock.
- Stage 2: five row sums, each sign-extended by 3 guard bits.
- Stage 3: total of the five row sums, PIX_W+COEFF_W+6 = 30 bits signed.
- Stage 4 (output):
  - Add the rounding constant 2^(COEFF_FRAC-1) (0 when COEFF_FRAC=0).
  - Arithmetic shift right by COEFF_FRAC.
  - Saturate: a result < 0 gives 0; a result > 2^PIX_W-1 gives 2^PIX_W-1 (255 at defaults).
- The pipeline advances every clock regardless of dv_i.
- A sideband shift register carries {dv, hs, vs} in step with the data, so dv_o marks exactly the outputs derived from a window updated by a valid column.
- Window is not cleared at line or frame boundaries. Border handling is upstream's responsibility.

## Timing
- Latency from input to its output is 5 clocks.
  - Column presented with dv_i=1 in cycle k: window updates at the end of k.
  - Products valid in k+1, row sums in k+2, total in k+3, pix_o registered and visible in cycle k+5.
- dv_o, hs_o and vs_o are hs/vs/dv delayed by exactly 5 clocks, registered.
- Throughput is one pixel per clock. Back-to-back dv_i is supported; there is no backpressure.
- Reset (rst=1, asynchronous):
  - Window, all pipeline registers and the sideband delay clear to 0 immediately.
  - dv_o=0, hs_o=0, vs_o=0, pix_o=0.
- Reset mid-frame: in-flight results are discarded. After release, the first dv_o=1 appears 5 clocks after the first dv_i=1, computed on a zero-filled window.
- Gaps in dv_i: outputs during the gap carry dv_o=0; pix_o content is don't-care. A held window produces no duplicate valid output.

## Configuration
- FIR_BYPASS_EN defined:
  - bypass_i port exists.
  - When bypass_i=1, stage 4 outputs the center pixel w[2][2] carried down a parallel delay. Latency and sidebands are identical to the filtered path.
  - bypass_i is sampled at the window stage, together with the column it accompanies.
- FIR_BYPASS_EN undefined: no bypass_i port and no center delay line; the output is always filtered.

## Test plan
- Identity:
  - Stimulus: coeff22=256, all others 0, 20 consecutive columns with px2_i = 10, 20, 30, …
  - Required: the output at 5 clocks after the column carrying px2_i=30 equals 10 (center is two columns back), with dv_o=1 on every matching clock.
- Box:
  - Stimulus: all coefficients 10, all pixels 200, continuous valid.
  - Required: once the window is full, pix_o = (50000+128)>>8 = 195.
- Saturation:
  - Stimulus 1: coeff22=1024, center pixel 100. Required: pix_o=255.
  - Stimulus 2: coeff22=-256, center pixel 100. Required: pix_o=0.
- Rounding:
  - Stimulus 1: coeff22=128, center pixel 3. Required: pix_o=2.
  - Stimulus 2: coeff22=128, center pixel 1. Required: pix_o=1.
- Sidebands and reset:
  - Stimulus 1: hs_i pulse, and dv_i toggling 1,0,1,1. Required: identical pattern on hs_o/dv_o 5 clocks later.
  - Stimulus 2: rst asserted mid-line. Required: all outputs 0 within the same cycle, and the first dv_o=1 arrives 5 clocks after the first post-reset dv_i.
- With FIR_BYPASS_EN:
  - Stimulus: bypass_i=1, all coefficients 0, center pixel 77.
  - Required: pix_o=77 at the same latency.
